// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes,
// opcode constants, the canonical NOP word and an immediate range helper.
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    localparam logic [6:0]  OP_IMM    = 7'h13;
    localparam logic [6:0]  OP_LUI    = 7'h37;
    localparam logic [6:0]  OP_JAL    = 7'h6F;
    localparam logic [6:0]  OP_BRANCH = 7'h63;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_REG    = 7'h33;

    // Upper-bit masks whose bits must all be equal for an immediate to fit.
    localparam logic [31:0] MASK_IS   = 32'hFFFF_F800; // imm[31:11]
    localparam logic [31:0] MASK_B    = 32'hFFFF_F000; // imm[31:12]
    localparam logic [31:0] MASK_J    = 32'hFFF0_0000; // imm[31:20]

    // True when the masked bits of v are all zero or all one (value fits
    // in the signed field below the mask).
    function automatic logic imm_fits(input logic [31:0] v, input logic [31:0] mask);
        return ((v & mask) == 32'h0) || ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output of the instruction encoder.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; while valid is high and ready is low the source holds
// valid and its payload unchanged; ready never depends on valid.
interface inst_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              addr_clr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [15:0]       inst_count;

    // Producer of field bundles and consumer of encoded words.
    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output addr_clr, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err, inst_count
    );

    // The encoder itself.
    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  addr_clr, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err, inst_count
    );
endinterface

// File: rtl/inst_encoder_field_packer.sv
// Combinational packer: RV32I fields plus format select -> {word, err}.
// Optional build macro INST_ENC_ERR_NOP_EN replaces every errored word with NOP.
module inst_field_packer
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);
    logic        is_shift;
    logic [11:0] i_imm;

    // I-type immediate field: shift-immediates put funct7 above the shamt.
    always_comb begin
        is_shift = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));
        i_imm    = is_shift ? {funct7, imm[4:0]} : imm[11:0];
    end

    // Assemble the word from truncated fields and flag lost immediate bits.
    always_comb begin
        word = NOP_INST;
        err  = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                word = {i_imm, rs1, funct3, rd, opcode};
                err  = ~imm_fits(imm, MASK_IS);
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = ~imm_fits(imm, MASK_IS);
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = ~imm_fits(imm, MASK_B) | imm[0];
            end
            FMT_U: begin
                word = {imm[31:12], rd, opcode};
                err  = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = ~imm_fits(imm, MASK_J) | imm[0];
            end
            default: begin
                word = NOP_INST;
                err  = 1'b1;
            end
        endcase
`ifdef INST_ENC_ERR_NOP_EN
        if (err) begin
            word = NOP_INST;
        end
`endif
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder top: field packer, 2-entry output queue,
// byte-address counter (clearable) and accepted-bundle counter.
// Optional build macro INST_ENC_ERR_NOP_EN (see inst_field_packer).
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          reset,
    inst_encoder_if.slave bus
);
    logic [31:0]       enc_word;
    logic              enc_err;

    logic [1:0]        occ_q, occ_d;
    logic [31:0]       head_inst_q, head_inst_d;
    logic [31:0]       tail_inst_q, tail_inst_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;
    logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
    logic              head_err_q, head_err_d;
    logic              tail_err_q, tail_err_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [15:0]       inst_count_q, inst_count_d;

    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] slot_addr;

    inst_field_packer u_packer (
        .fmt    (bus.fmt),
        .opcode (bus.opcode),
        .rd     (bus.rd),
        .rs1    (bus.rs1),
        .rs2    (bus.rs2),
        .funct3 (bus.funct3),
        .funct7 (bus.funct7),
        .imm    (bus.imm),
        .word   (enc_word),
        .err    (enc_err)
    );

    // Handshake qualifiers come from registered occupancy only.
    always_comb begin
        in_ready  = (occ_q != 2'd2);
        out_valid = (occ_q != 2'd0);
        push      = bus.in_valid & in_ready;
        pop       = out_valid & bus.out_ready;
    end

    // Address and count bookkeeping; a coincident clear feeds BASE_ADDR to the bundle.
    always_comb begin
        slot_addr    = bus.addr_clr ? BASE_ADDR : addr_cnt_q;
        addr_cnt_d   = slot_addr;
        inst_count_d = inst_count_q;
        if (push) begin
            addr_cnt_d   = slot_addr + ADDR_W'(4);
            inst_count_d = inst_count_q + 16'd1;
        end
    end

    // Queue next state: head is the output register, tail holds the second entry.
    always_comb begin
        occ_d       = occ_q;
        head_inst_d = head_inst_q;
        head_addr_d = head_addr_q;
        head_err_d  = head_err_q;
        tail_inst_d = tail_inst_q;
        tail_addr_d = tail_addr_q;
        tail_err_d  = tail_err_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_inst_d = enc_word;
                    head_addr_d = slot_addr;
                    head_err_d  = enc_err;
                    occ_d       = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_inst_d = enc_word;
                    head_addr_d = slot_addr;
                    head_err_d  = enc_err;
                end else if (push) begin
                    tail_inst_d = enc_word;
                    tail_addr_d = slot_addr;
                    tail_err_d  = enc_err;
                    occ_d       = 2'd2;
                end else if (pop) begin
                    occ_d       = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_inst_d = tail_inst_q;
                    head_addr_d = tail_addr_q;
                    head_err_d  = tail_err_q;
                    occ_d       = 2'd1;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q        <= 2'd0;
            head_inst_q  <= 32'h0;
            head_addr_q  <= '0;
            head_err_q   <= 1'b0;
            tail_inst_q  <= 32'h0;
            tail_addr_q  <= '0;
            tail_err_q   <= 1'b0;
            addr_cnt_q   <= BASE_ADDR;
            inst_count_q <= 16'h0;
        end else begin
            occ_q        <= occ_d;
            head_inst_q  <= head_inst_d;
            head_addr_q  <= head_addr_d;
            head_err_q   <= head_err_d;
            tail_inst_q  <= tail_inst_d;
            tail_addr_q  <= tail_addr_d;
            tail_err_q   <= tail_err_d;
            addr_cnt_q   <= addr_cnt_d;
            inst_count_q <= inst_count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_inst   = head_inst_q;
    assign bus.out_addr   = head_addr_q;
    assign bus.out_err    = head_err_q;
    assign bus.inst_count = inst_count_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction decode path: accepts RV32I instruction fields plus a format select and assembles the 32-bit instruction word.
- Tags each word with a sequential byte address.
- Buffers results in a 2-entry output queue that feeds the instruction-memory loader and the self-test program generator.
- Valid/ready on both sides; the address counter is clearable.

Parameters:
ADDR_W, 32, width of the address counter and out_addr
BASE_ADDR, 32'h0000_0000, address assigned to the first instruction after reset or addr_clr

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
fmt  input  3  format select (package codes)
opcode  input  7  inst[6:0]
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  function code
funct7  input  7  function code (R-type; I-type shifts)
imm  input  32  full sign-extended immediate value, byte offset for B/J
addr_clr  input  1  reload the address counter with BASE_ADDR
out_valid  output  1  queue head valid
out_ready  input  1  consumer accepts head
out_inst  output  32  encoded instruction
out_addr  output  ADDR_W  byte address of out_inst
out_err  output  1  immediate out of range, misaligned, or illegal fmt
inst_count  output  16  accepted bundles since reset, wraps

Behaviour:
- Reset (synchronous, active-high): queue empty, out_valid=0, out_inst=0, out_addr=0, out_err=0, inst_count=0, addr counter=BASE_ADDR, in_ready=1 on the following cycle.
- Accept when in_valid & in_ready. in_ready = (occupancy < 2). Pop when out_valid & out_ready. Push and pop in the same cycle are legal at any occupancy < 2; at occupancy 2, in_ready=0 and the pop still occurs.
- Latency: an accepted bundle is visible at the head no earlier than the next cycle (registered enqueue, combinational encode before the register). Order is strictly FIFO. Head outputs stay stable while out_valid & ~out_ready.
- Encoding:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}. If opcode=7'h13 and funct3 is 001 or 101, use {funct7,imm[4:0]} in place of imm[11:0].
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Error rules, checked at accept:
  - I/S: imm[31:11] not all equal → err.
  - B: imm[31:12] not all equal, or imm[0]=1 → err.
  - J: imm[31:20] not all equal, or imm[0]=1 → err.
  - U: imm[11:0]≠0 → err.
  - Illegal fmt (6, 7): err, word = 32'h0000_0013.
  - Otherwise the word is encoded from the truncated bits with out_err=1.
- Address: each accepted bundle takes the current counter value; the counter then advances by 4, modulo 2^ADDR_W with silent wrap.
- addr_clr: counter ← BASE_ADDR. If coincident with an accept, that bundle gets BASE_ADDR and the counter becomes BASE_ADDR+4. Entries already queued are unaffected.
- inst_count increments per accept, wraps at 16'hFFFF→0. addr_clr does not clear it.
- Reset mid-stream discards queued entries; no output is produced for them.

Optional Feature:
- Macro INST_ENC_ERR_NOP_EN.
- Defined: any errored bundle is enqueued as 32'h0000_0013 with out_err=1; its address is still consumed.
- Undefined: errored bundles carry the truncated encoding described above with out_err=1.

Decomposition:
- Shared package: format codes FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5; constant NOP_INST=32'h0000_0013; opcode constants OP_IMM=7'h13, OP_LUI=7'h37, OP_JAL=7'h6F, OP_BRANCH=7'h63, OP_STORE=7'h23, OP_REG=7'h33.
- One sub-module, inst_field_packer: purely combinational; fields+fmt → {word, err}.
- The top level holds the 2-entry queue and both counters.

Test Plan:
- I-type: fmt=I, op=13, rd=1, rs1=0, f3=0, imm=5 after reset → out_inst=0x00500093, out_addr=0, out_err=0, one cycle after accept.
- R/S back-to-back: add x3,x1,x2 (f7=0, f3=0, op=33), then sw x2,8(x1) (f3=2, op=23) → 0x002081B3 @0, then 0x0020A423 @4.
- B/J/U: beq x0,x0,imm=-4 → 0xFE000EE3; jal x0,imm=0 → 0x0000006F; lui x5,imm=0x12345000 → 0x123452B7; all with out_err=0.
- Errors: I imm=0x800 → err=1; B imm=6 with imm[0]=0 → err=0, but imm=5 → err=1; fmt=7 → 0x00000013, err=1. Repeat with INST_ENC_ERR_NOP_EN → every err entry equals 0x00000013.
- Backpressure: out_ready=0, present 3 bundles → in_ready drops after the 2nd accept; raise out_ready → order preserved; simultaneous push/pop at occupancy 1 holds occupancy at 1.
- addr_clr coincident with accept at counter=0x40 → that entry gets out_addr=0, the next gets 4. With ADDR_W=4, wrap 0xC→0x0. Reset with 2 entries queued → out_valid=0 the next cycle and inst_count=0.
